tx_fire_scheduler: RTL and testbench



---
 rtl/tx_pkg.sv | 25 ++
 rtl/tx_elem_pulse.sv | 34 +++
 rtl/tx_fire_scheduler.sv | 109 ++++++++++
 tb/tb_tx_fire_scheduler.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/tx_pkg.sv
// Shared types and constants for the transmit fire scheduler (tx_fire_scheduler).
package tx_pkg;

  localparam int NUM_ELEM = 8;
  localparam int DELAY_W  = 8;
  localparam int HW_W     = 4;
  localparam int ADDR_W   = $clog2(NUM_ELEM);
  // Wide enough for max delay plus two half-cycles, so compares never wrap.
  localparam int CMP_W    = DELAY_W + HW_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FIRE = 2'd1,
    DONE = 2'd2
  } tx_state_e;

  typedef logic [DELAY_W-1:0] delay_t;
  typedef logic [HW_W-1:0]    hw_t;
  typedef logic [CMP_W-1:0]   tcnt_t;

  function automatic delay_t max_delay(input delay_t a, input delay_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tx_elem_pulse.sv
// Per-element bipolar pulse generator: registered pos/neg windows against the event time t.
module tx_elem_pulse
  import tx_pkg::*;
(
  input  logic   clock,
  input  logic   reset,
  input  logic   en,
  input  delay_t d,
  input  hw_t    hw,
  input  tcnt_t  t,
  output logic   pos,
  output logic   neg
);

  tcnt_t d_ext;
  tcnt_t pos_end;
  tcnt_t neg_end;

  assign d_ext   = tcnt_t'(d);
  assign pos_end = d_ext + tcnt_t'(hw);
  assign neg_end = pos_end + tcnt_t'(hw);

  // The two windows are disjoint, so pos and neg can never overlap.
  always_ff @(posedge clock) begin
    if (reset) begin
      pos <= 1'b0;
      neg <= 1'b0;
    end else begin
      pos <= en && (t >= d_ext) && (t < pos_end);
      neg <= en && (t >= pos_end) && (t < neg_end);
    end
  end

endmodule

// File: rtl/tx_fire_scheduler.sv
// Transmit-event controller: snapshots the delay table on start and fires one bipolar pulse per element.
// Optional element-walk delays are enabled by defining TX_ELEMENT_WALK_EN.
module tx_fire_scheduler
  import tx_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  hw_t                 half_width,
  input  logic                dly_wr,
  input  logic [ADDR_W-1:0]   dly_addr,
  input  delay_t              dly_data,
`ifdef TX_ELEMENT_WALK_EN
  input  logic                walk,
`endif
  output logic                busy,
  output logic                done,
  output logic [NUM_ELEM-1:0] posOutput,
  output logic [NUM_ELEM-1:0] negOutput,
  output tx_state_e           dbg_state
);

  tx_state_e state;
  delay_t    shadow [NUM_ELEM];
  delay_t    active [NUM_ELEM];
  delay_t    snap   [NUM_ELEM];
  delay_t    snap_max;
  hw_t       hw;
  hw_t       hw_eff;
  tcnt_t     t;
  tcnt_t     last_t;

  assign dbg_state = state;

  // Snapshot candidates as they will be latched at an accepted start.
  always_comb begin
    hw_eff   = (half_width == '0) ? hw_t'(1) : half_width;
    snap_max = '0;
    for (int i = 0; i < NUM_ELEM; i++) begin
      snap[i] = shadow[i];
`ifdef TX_ELEMENT_WALK_EN
      if (walk) snap[i] = delay_t'(i * 2 * int'(hw_eff));
`endif
      snap_max = max_delay(snap_max, snap[i]);
    end
  end

  // Host writes land in the shadow copy only; the running event uses active.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_ELEM; i++) shadow[i] <= '0;
    end else if (dly_wr) begin
      shadow[dly_addr] <= dly_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      t      <= '0;
      hw     <= '0;
      last_t <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      for (int i = 0; i < NUM_ELEM; i++) active[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            active <= snap;
            hw     <= hw_eff;
            last_t <= tcnt_t'(snap_max) + tcnt_t'(hw_eff) + tcnt_t'(hw_eff) - tcnt_t'(1);
            t      <= '0;
            busy   <= 1'b1;
            state  <= FIRE;
          end
        end
        FIRE: begin
          t <= t + tcnt_t'(1);
          if (t == last_t) state <= DONE;
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  for (genvar g = 0; g < NUM_ELEM; g++) begin : g_elem
    tx_elem_pulse u_pulse (
      .clock (clock),
      .reset (reset),
      .en    (state == FIRE),
      .d     (active[g]),
      .hw    (hw),
      .t     (t),
      .pos   (posOutput[g]),
      .neg   (negOutput[g])
    );
  end

endmodule

// File: tb/tb_tx_fire_scheduler.sv
// Self-checking bench for tx_fire_scheduler: event-level reference model feeding an expected-word queue.
module tb_tx_fire_scheduler;
  import tx_pkg::*;

  logic                clock = 1'b0;
  logic                reset;
  logic                start;
  hw_t                 half_width;
  logic                dly_wr;
  logic [ADDR_W-1:0]   dly_addr;
  delay_t              dly_data;
`ifdef TX_ELEMENT_WALK_EN
  logic                walk;
`endif
  logic                busy;
  logic                done;
  logic [NUM_ELEM-1:0] posOutput;
  logic [NUM_ELEM-1:0] negOutput;
  tx_state_e           dbg_state;

  int vectors     = 0;
  int miscompares = 0;
  int ev_id       = 0;

  // Expected word per cycle: {busy, done, negOutput, posOutput}
  logic [17:0] exp_q[$];
  int          shadow_m[NUM_ELEM];

  tx_fire_scheduler dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .half_width (half_width),
    .dly_wr     (dly_wr),
    .dly_addr   (dly_addr),
    .dly_data   (dly_data),
`ifdef TX_ELEMENT_WALK_EN
    .walk       (walk),
`endif
    .busy       (busy),
    .done       (done),
    .posOutput  (posOutput),
    .negOutput  (negOutput),
    .dbg_state  (dbg_state)
  );

  // Clock / reset
  always #5 clock = ~clock;

  function automatic logic [17:0] obs();
    return {busy, done, negOutput, posOutput};
  endfunction

  task automatic check_eq(input string tag, input logic [17:0] got, input logic [17:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic sample(input string tag);
    logic [17:0] e;
    @(negedge clock);
    e = exp_q.pop_front();
    check_eq(tag, obs(), e);
  endtask

  // Driver tasks
  task automatic idle_check(input int n);
    for (int c = 0; c < n; c++) begin
      exp_q.push_back('0);
      sample($sformatf("idle%0d", c));
    end
  endtask

  task automatic load_delay(input int a, input int v);
    dly_wr   = 1'b1;
    dly_addr = ADDR_W'(a);
    dly_data = delay_t'(v);
    exp_q.push_back('0);
    sample($sformatf("load_e%0d", a));
    shadow_m[a] = v;
    dly_wr = 1'b0;
  endtask

  // mode 0: quiet, 1: random start/write/half_width noise, 2: start + write d0=9 at k=2
  task automatic run_event(input int h, input bit w, input int mode, input int abort_k);
    int hw_e;
    int mx;
    int len;
    int kmax;
    int d[NUM_ELEM];
    logic [17:0] wv;

    hw_e = (h == 0) ? 1 : h;
    mx   = 0;
    for (int i = 0; i < NUM_ELEM; i++) begin
      d[i] = w ? i * 2 * hw_e : shadow_m[i];
      if (d[i] > mx) mx = d[i];
    end
    len = mx + 2 * hw_e;

    // Sample k follows the k-th edge after the accepting edge; outputs show time t = k-1.
    for (int k = 0; k <= len + 1; k++) begin
      wv     = '0;
      wv[17] = (k <= len);
      wv[16] = (k == len + 1);
      if (k >= 1 && k <= len) begin
        for (int i = 0; i < NUM_ELEM; i++) begin
          wv[i]     = (k - 1 >= d[i]) && (k - 1 < d[i] + hw_e);
          wv[8 + i] = (k - 1 >= d[i] + hw_e) && (k - 1 < d[i] + 2 * hw_e);
        end
      end
      exp_q.push_back(wv);
    end

    start      = 1'b1;
    half_width = hw_t'(h);
`ifdef TX_ELEMENT_WALK_EN
    walk = w;
`endif
    dly_wr = 1'b0;
    if (mode == 1 && $urandom_range(0, 1) == 1) begin
      // Write on the accepting edge: excluded from this snapshot.
      dly_wr   = 1'b1;
      dly_addr = ADDR_W'($urandom_range(0, NUM_ELEM - 1));
      dly_data = delay_t'($urandom_range(0, 255));
      shadow_m[dly_addr] = int'(dly_data);
    end

    kmax = (abort_k >= 0) ? abort_k : len + 1;
    for (int k = 0; k <= kmax; k++) begin
      sample($sformatf("ev%0d_k%0d", ev_id, k));
      start  = 1'b0;
      dly_wr = 1'b0;
      if (k < len + 1) begin
        if (mode == 1) begin
          start      = (k == len) ? 1'b1 : 1'($urandom_range(0, 1));
          half_width = hw_t'($urandom_range(0, 15));
`ifdef TX_ELEMENT_WALK_EN
          walk = 1'($urandom_range(0, 1));
`endif
          if ($urandom_range(0, 3) == 0) begin
            dly_wr   = 1'b1;
            dly_addr = ADDR_W'($urandom_range(0, NUM_ELEM - 1));
            dly_data = delay_t'($urandom_range(0, 255));
            shadow_m[dly_addr] = int'(dly_data);
          end
        end else if (mode == 2 && k == 2) begin
          start    = 1'b1;
          dly_wr   = 1'b1;
          dly_addr = '0;
          dly_data = 8'd9;
          shadow_m[0] = 9;
        end
      end
    end

    if (abort_k >= 0) begin
      exp_q.delete();
      reset  = 1'b1;
      start  = 1'b0;
      dly_wr = 1'b0;
      exp_q.push_back('0);
      sample($sformatf("ev%0d_reset", ev_id));
      reset = 1'b0;
      for (int i = 0; i < NUM_ELEM; i++) shadow_m[i] = 0;
    end
`ifdef TX_ELEMENT_WALK_EN
    walk = 1'b0;
`endif
    ev_id++;
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    half_width = '0;
    dly_wr     = 1'b0;
    dly_addr   = '0;
    dly_data   = '0;
`ifdef TX_ELEMENT_WALK_EN
    walk       = 1'b0;
`endif
    for (int i = 0; i < NUM_ELEM; i++) shadow_m[i] = 0;

    repeat (3) @(negedge clock);
    reset = 1'b0;
    idle_check(20);

    // All delays zero, half width 2
    run_event(2, 1'b0, 0, -1);
    idle_check(2);

    // Linear steering d_i = 3*i, half width 1
    for (int i = 0; i < NUM_ELEM; i++) load_delay(i, 3 * i);
    run_event(1, 1'b0, 0, -1);

    // Mid-event start is ignored; the mid-event write lands in the next event
    run_event(1, 1'b0, 2, -1);
    run_event(1, 1'b0, 0, -1);

    // Zero half width behaves as one; back-to-back start at first idle cycle
    run_event(0, 1'b0, 0, -1);
    idle_check(1);

    for (int r = 0; r < 6; r++) begin
      for (int j = 0; j < 3; j++) load_delay($urandom_range(0, NUM_ELEM - 1), $urandom_range(0, 255));
      run_event($urandom_range(0, 15), 1'b0, 1, -1);
      idle_check($urandom_range(0, 2));
    end

    // Reset at t=2 of an event, then the cleared table fires all elements together
    load_delay(5, 40);
    run_event(2, 1'b0, 0, 2);
    idle_check(3);
    run_event(3, 1'b0, 0, -1);

`ifdef TX_ELEMENT_WALK_EN
    for (int i = 0; i < NUM_ELEM; i++) load_delay(i, 200 - i);
    run_event(1, 1'b1, 0, -1);
    run_event($urandom_range(1, 15), 1'b1, 1, -1);
    run_event(1, 1'b0, 0, -1);
`endif

    idle_check(4);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
